// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status inputs and stage enable/flush controls.
// The pipeline side uses the master modport and the controller uses the slave modport.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             ex_is_load;
  logic [4:0]       ex_rd;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             mem_branch_taken;
  logic             dmem_req;
  logic             dmem_ready;
  logic             imem_ready;
  logic             pc_en;
  logic             en_fd;
  logic             en_de;
  logic             en_em;
  logic             en_mw;
  logic             flush_fd;
  logic             flush_de;
  logic             flush_em;
  logic             halted;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output ex_is_load, ex_rd, id_rs, id_rt, id_use_rs, id_use_rt,
           mem_branch_taken, dmem_req, dmem_ready, imem_ready,
    input  pc_en, en_fd, en_de, en_em, en_mw, flush_fd, flush_de, flush_em,
           halted, stall_cycles
  );

  modport slave (
    input  ex_is_load, ex_rd, id_rs, id_rt, id_use_rs, id_use_rt,
           mem_branch_taken, dmem_req, dmem_ready, imem_ready,
    output pc_en, en_fd, en_de, en_em, en_mw, flush_fd, flush_de, flush_em,
           halted, stall_cycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch squash, fetch miss, dmem wait with timeout halt.
// Optional stall counter is built when PIPE_STALL_CNT_EN is defined.
module pipe_hazard_ctrl #(
  parameter int WAIT_TIMEOUT = 64,
  parameter int CNT_W        = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  pipe_hazard_ctrl_if.slave  hz
);
  typedef enum logic [1:0] {RUN, DWAIT, HALT} state_t;

  localparam logic [7:0] TIMEOUT = 8'(WAIT_TIMEOUT);

  // Control vector layout: {pc_en, en_fd, en_de, en_em, en_mw, flush_fd, flush_de, flush_em}
  localparam logic [7:0] CTL_FREE   = 8'b11111_000;
  localparam logic [7:0] CTL_BRANCH = 8'b11111_111;
  localparam logic [7:0] CTL_LU     = 8'b00111_010;
  localparam logic [7:0] CTL_IMISS  = 8'b01111_100;
  localparam logic [7:0] CTL_FREEZE = 8'b00000_000;
  localparam logic [7:0] CTL_RESET  = 8'b00000_111;

  state_t     state_q, state_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic       lu;
  logic [7:0] run_ctl;
  logic [7:0] ctl;

  assign lu = hz.ex_is_load && (hz.ex_rd != 5'd0) &&
              ((hz.id_use_rs && (hz.id_rs == hz.ex_rd)) ||
               (hz.id_use_rt && (hz.id_rt == hz.ex_rd)));

  // RUN behaviour without the dmem-wait condition; also reused when a wait completes.
  always_comb begin
    run_ctl = CTL_FREE;
    if (hz.mem_branch_taken) begin
      run_ctl = CTL_BRANCH;
    end else if (lu) begin
      run_ctl = CTL_LU;
    end else if (!hz.imem_ready) begin
      run_ctl = CTL_IMISS;
    end
  end

  always_comb begin
    ctl     = run_ctl;
    state_d = state_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      RUN: begin
        if (hz.dmem_req && !hz.dmem_ready) begin
          ctl     = CTL_FREEZE;
          state_d = DWAIT;
          wcnt_d  = 8'd1;
        end
      end
      DWAIT: begin
        if (hz.dmem_ready) begin
          state_d = RUN;
          wcnt_d  = 8'd0;
        end else if (wcnt_q == TIMEOUT) begin
          ctl     = CTL_FREEZE;
          state_d = HALT;
        end else begin
          ctl     = CTL_FREEZE;
          wcnt_d  = wcnt_q + 8'd1;
        end
      end
      HALT: begin
        ctl = CTL_FREEZE;
      end
      default: begin
        ctl     = CTL_FREEZE;
        state_d = RUN;
      end
    endcase
    if (!rst_n) begin
      ctl = CTL_RESET;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      wcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign hz.pc_en    = ctl[7];
  assign hz.en_fd    = ctl[6];
  assign hz.en_de    = ctl[5];
  assign hz.en_em    = ctl[4];
  assign hz.en_mw    = ctl[3];
  assign hz.flush_fd = ctl[2];
  assign hz.flush_de = ctl[1];
  assign hz.flush_em = ctl[0];
  assign hz.halted   = rst_n && (state_q == HALT);

`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_q, stall_d;

  // Saturating count of cycles the PC was held, excluding the halted state.
  always_comb begin
    stall_d = stall_q;
    if (!ctl[7] && (state_q != HALT) && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign hz.stall_cycles = stall_q;
`else
  assign hz.stall_cycles = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios then random traffic against a behavioural model.
module tb_pipe_hazard_ctrl;
  localparam int T     = 4;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_hazard_ctrl #(.WAIT_TIMEOUT(T), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (bus)
  );

  typedef struct {
    logic [8:0]       ctl;
    logic [CNT_W-1:0] stall;
    int               cyc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc_n    = 0;

  // Reference model state: 0 running, 1 waiting on data memory, 2 halted.
  int     m_mode   = 0;
  int     m_waited = 0;
  longint m_stalls = 0;

  // Monitor: the DUT presents a control word every cycle.
  always @(negedge clk) begin
    exp_t       e;
    logic [8:0] act;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      act = {bus.pc_en, bus.en_fd, bus.en_de, bus.en_em, bus.en_mw,
             bus.flush_fd, bus.flush_de, bus.flush_em, bus.halted};
      checks++;
      if (act !== e.ctl) begin
        failures++;
        $display("FAIL ctl cycle %0d: got %b want %b (pc,fd,de,em,mw,ffd,fde,fem,halt)",
                 e.cyc, act, e.ctl);
      end
      checks++;
      if (bus.stall_cycles !== e.stall) begin
        failures++;
        $display("FAIL stall_cycles cycle %0d: got %0d want %0d", e.cyc, bus.stall_cycles, e.stall);
      end
    end
  end

  task automatic step(input logic r, input logic ld, input logic [4:0] rd, input logic [4:0] rs,
                      input logic [4:0] rt, input logic urs, input logic urt, input logic br,
                      input logic req, input logic rdy, input logic im);
    exp_t       e;
    logic [8:0] run_v;
    logic [8:0] out_v;
    logic       hit;
    int         mode_before;
    @(posedge clk);
    #1;
    rst_n                = r;
    bus.ex_is_load       = ld;
    bus.ex_rd            = rd;
    bus.id_rs            = rs;
    bus.id_rt            = rt;
    bus.id_use_rs        = urs;
    bus.id_use_rt        = urt;
    bus.mem_branch_taken = br;
    bus.dmem_req         = req;
    bus.dmem_ready       = rdy;
    bus.imem_ready       = im;

    hit = ld && (rd != 0) && ((urs && rs == rd) || (urt && rt == rd));
    if (br)       run_v = {5'b11111, 3'b111, 1'b0};
    else if (hit) run_v = {5'b00111, 3'b010, 1'b0};
    else if (!im) run_v = {5'b01111, 3'b100, 1'b0};
    else          run_v = {5'b11111, 3'b000, 1'b0};

    e.cyc       = cyc_n;
    e.stall     = CNT_W'(m_stalls);
    mode_before = m_mode;
    if (!r) begin
      out_v    = {5'b00000, 3'b111, 1'b0};
      m_mode   = 0;
      m_waited = 0;
      m_stalls = 0;
    end else begin
      if (m_mode == 0) begin
        if (req && !rdy) begin
          out_v    = 9'b0;
          m_mode   = 1;
          m_waited = 1;
        end else begin
          out_v = run_v;
        end
      end else if (m_mode == 1) begin
        if (rdy) begin
          out_v  = run_v;
          m_mode = 0;
        end else if (m_waited >= T) begin
          out_v  = 9'b0;
          m_mode = 2;
        end else begin
          out_v    = 9'b0;
          m_waited = m_waited + 1;
        end
      end else begin
        out_v = 9'b0_0000_000_1;
      end
`ifdef PIPE_STALL_CNT_EN
      if (!out_v[8] && mode_before != 2 && m_stalls < 64'hFFFF_FFFF) m_stalls = m_stalls + 1;
`endif
    end
    e.ctl = out_v;
    sb.push_back(e);
    cyc_n++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
  endtask

  initial begin
    // Reset and free run
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(4);
    // Load-use on rs, then on rt
    step(1, 1, 5, 5, 0, 1, 0, 0, 0, 1, 1);
    idle(2);
    step(1, 1, 9, 0, 9, 0, 1, 0, 0, 1, 1);
    // Branch overrides load-use
    step(1, 1, 5, 5, 0, 1, 0, 1, 0, 1, 1);
    // Load-use plus fetch miss: fetch stays frozen
    step(1, 1, 7, 0, 7, 0, 1, 0, 0, 1, 0);
    // Fetch miss alone; then load to r0 is no hazard; match without use is no hazard
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0, 1, 1, 0, 0, 1, 1);
    step(1, 1, 3, 3, 3, 0, 0, 0, 0, 1, 1);
    // Data wait 3 cycles, completing with a branch in MEM
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1);
    idle(2);
    // Timeout into halt, stays halted, cleared by reset
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(3);
    // Reset during a wait
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    idle(2);
    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      step(($urandom % 40) != 0, 1'($urandom % 2), 5'($urandom % 4), 5'($urandom % 4),
           5'($urandom % 4), 1'($urandom % 2), 1'($urandom % 2), ($urandom % 6) == 0,
           ($urandom % 3) == 0, ($urandom % 10) >= 4, ($urandom % 5) != 0);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending entries want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
